// File: rtl/input_debounce.sv
// Per-channel input conditioner: a SYNC_STAGES-deep synchronizer followed by a filter
// that accepts a new level only after DEBOUNCE_CYCLES consecutive mismatching samples.
module input_debounce #(
  parameter int WIDTH           = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             anrst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] busy
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  (* ASYNC_REG = "TRUE" *)
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  s;

  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]         out_q, out_d;
  logic [WIDTH-1:0]         busy_q, busy_d;

  // NOTE: every flop, synchronizer stages included, is reset so s and out agree (both 0)
  // on release and no channel starts with a phantom mismatch.
  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      sync_q <= '0;
    end else begin
      // NOTE: non-blocking assignment lets each stage capture its predecessor's old value.
      sync_q <= {sync_q[SYNC_STAGES-2:0], in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    // NOTE: defaults first, so every path through the loop assigns every output (no latches).
    cnt_d  = cnt_q;
    out_d  = out_q;
    busy_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s[i] == out_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        out_d[i] = s[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
      busy_d[i] = (cnt_d[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      cnt_q  <= '0;
      out_q  <= '0;
      busy_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      busy_q <= busy_d;
    end
  end

  assign out  = out_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_input_debounce.sv
// Scoreboarded bench for input_debounce (4 channels, 2 sync stages, 4-cycle filter)
// plus a second 1-channel instance with a 1-cycle filter.
module tb_input_debounce;

  localparam int DC = 4;

  typedef struct {
    logic [3:0] out;
    logic [3:0] busy;
  } exp_t;

  logic       clk = 1'b0;
  logic       anrst;
  logic [3:0] in_r;
  logic [3:0] out_w, busy_w;
  logic [0:0] in1_r, out1_w, busy1_w;

  int n_vec = 0;
  int n_bad = 0;

  exp_t sb_q[$];

  // Reference state: second sync stage and last DC filter samples.
  logic [3:0] m_sync0, m_s, m_out;
  logic [3:0] m_hist [DC];

  always #5 clk = ~clk;

  input_debounce #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) u_dut (
    .clk(clk), .anrst(anrst), .in(in_r), .out(out_w), .busy(busy_w)
  );

  input_debounce #(.WIDTH(1), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) u_dut1 (
    .clk(clk), .anrst(anrst), .in(in1_r), .out(out1_w), .busy(busy1_w)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sync0 = '0;
    m_s     = '0;
    m_out   = '0;
    for (int j = 0; j < DC; j++) m_hist[j] = '0;
  endtask

  // A channel flips when each of its last DC filter samples differed from its output.
  task automatic model_step(input logic [3:0] v, output exp_t e);
    logic [3:0] acc;
    logic [3:0] bsy;
    if (!anrst) begin
      model_reset();
      e.out  = '0;
      e.busy = '0;
    end else begin
      for (int j = DC - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = m_s;
      acc = '1;
      for (int j = 0; j < DC; j++) acc = acc & (m_hist[j] ^ m_out);
      bsy     = (m_s ^ m_out) & ~acc;
      m_out   = m_out ^ acc;
      m_s     = m_sync0;
      m_sync0 = v;
      e.out   = m_out;
      e.busy  = bsy;
    end
  endtask

  // Called at a falling edge: drive, predict, let one rising edge pass, compare.
  task automatic cycle(input logic [3:0] v, input logic v1);
    exp_t e;
    in_r     = v;
    in1_r[0] = v1;
    model_step(v, e);
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check("sb_out", {28'd0, out_w}, {28'd0, e.out});
      check("sb_busy", {28'd0, busy_w}, {28'd0, e.busy});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int         pat [9];
    int         trans;
    int         rise_at;
    logic       prev;
    logic       seen;
    logic [3:0] v;

    pat   = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
    anrst = 1'b0;
    in_r  = 4'hF;
    in1_r = 1'b0;
    model_reset();
    @(negedge clk);

    // Held in reset with all inputs high.
    for (int i = 0; i < 10; i++) cycle(4'hF, 1'b0);
    check("rst_out", {28'd0, out_w}, 32'd0);
    check("rst_out1", {31'd0, out1_w}, 32'd0);

    anrst = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      cycle(4'hF, 1'b0);
      if (i == 5) check("rel_out_e5", {28'd0, out_w}, 32'h0);
      if (i == 6) check("rel_out_e6", {28'd0, out_w}, 32'hF);
    end
    repeat (8) cycle(4'h0, 1'b0);
    check("idle_out", {28'd0, out_w}, 32'd0);

    // Clean step on channel 0.
    for (int i = 1; i <= 6; i++) begin
      cycle(4'h1, 1'b0);
      check("step_busy0", {31'd0, busy_w[0]}, {31'd0, (i >= 3 && i <= 5)});
      check("step_out0", {31'd0, out_w[0]}, {31'd0, (i == 6)});
    end
    repeat (8) cycle(4'h0, 1'b0);

    // Three-clock glitch on channel 1 is rejected; a four-clock pulse is accepted.
    repeat (3) cycle(4'h2, 1'b0);
    repeat (8) cycle(4'h0, 1'b0);
    check("glitch_out1", {31'd0, out_w[1]}, 32'd0);
    check("glitch_busy1", {31'd0, busy_w[1]}, 32'd0);
    repeat (4) cycle(4'h2, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle(4'h0, 1'b0);
      if (out_w[1]) seen = 1'b1;
    end
    check("pulse4_out1", {31'd0, seen}, 32'd1);

    // Bouncing channel 2: a single rise, ten cycles after the pattern starts.
    trans   = 0;
    rise_at = -1;
    prev    = out_w[2];
    for (int i = 0; i < 14; i++) begin
      v = (i < 9) ? {1'b0, (pat[i] != 0), 2'b00} : 4'h4;
      cycle(v, 1'b0);
      if (out_w[2] != prev) begin
        trans++;
        if (rise_at < 0) rise_at = i;
        prev = out_w[2];
      end
    end
    check("bounce_trans", trans, 1);
    check("bounce_rise", rise_at, 10);
    repeat (8) cycle(4'h0, 1'b0);

    // Two channels step together; reset lands mid-qualification.
    repeat (3) cycle(4'hA, 1'b0);
    check("pre_rst_busy", {28'd0, busy_w}, 32'hA);
    @(posedge clk);
    #1 anrst = 1'b0;
    #1;
    check("arst_out", {28'd0, out_w}, 32'd0);
    check("arst_busy", {28'd0, busy_w}, 32'd0);
    model_reset();
    @(negedge clk);
    anrst = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      cycle(4'hA, 1'b0);
      if (i == 5) check("arst_rel_e5", {28'd0, out_w}, 32'h0);
      if (i == 6) check("arst_rel_e6", {28'd0, out_w}, 32'hA);
    end

    // One-cycle filter instance: a one-clock pulse comes out three clocks later.
    for (int i = 1; i <= 6; i++) begin
      cycle(4'hA, (i == 1));
      check("d1_out", {31'd0, out1_w}, {31'd0, (i == 3)});
      check("d1_busy", {31'd0, busy1_w}, 32'd0);
    end

    // Toggling every clock never qualifies.
    repeat (8) cycle(4'h0, 1'b0);
    for (int i = 0; i < 20; i++) cycle((i % 2 == 0) ? 4'hF : 4'h0, 1'b0);
    check("toggle_out", {28'd0, out_w}, 32'd0);

    // Random slow-changing inputs.
    v = 4'h0;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(5) == 0) v[b] = ~v[b];
      end
      cycle(v, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
